lsu_mem_access: RTL

Multi-cycle load/store unit in the MEM stage of the pipeline. It consumes the memory-side control fields produced by instruction decode (MemRead, MemWrite, sign, length) together with the ALU-computed address and store data. It drives a handshaked word-wide data memory with byte enables, aligns and extends load data, and stalls the pipeline until each access completes, a misalignment is detected, or a timeout expires.

---
 rtl/lsu_mem_access_if.sv | 19 +
 rtl/lsu_mem_access.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access_if.sv
// Data-memory bus between the MEM-stage load/store unit and the word-wide data memory.
interface lsu_mem_access_if;
   logic        dmem_en;
   logic [3:0]  dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;

   modport master (
      output dmem_en, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ready
   );

   modport slave (
      input  dmem_en, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ready
   );
endinterface

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store unit: checks alignment, drives a handshaked word memory
// with byte enables, aligns/extends load data and stalls the pipeline until the
// access completes, is rejected, or times out.
module lsu_mem_access #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   input  logic                     mem_read,
   input  logic                     mem_write,
   input  logic                     sign,
   input  logic [1:0]               length,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   output logic                     stall,
   output logic                     done,
   output logic                     err,
   output logic [31:0]              rdata_out,
   lsu_mem_access_if.master         dmem
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT);

   logic [1:0]  state;
   logic [7:0]  cnt;
   logic [1:0]  off_q;
   logic [1:0]  len_q;
   logic        sign_q;

   logic        accept;
   logic        illegal;
   logic        timeout_hit;
   logic [3:0]  we_n;
   logic [31:0] wdata_n;
   logic [31:0] lane;
   logic [31:0] load_ext;

   // Request decode, legality check and pipeline stall.
   always_comb begin
      accept  = req_valid & (mem_read | mem_write);
      illegal = (length == 2'b11)
              | (mem_read & mem_write)
              | ((length == 2'b01) & addr[0])
              | ((length == 2'b10) & (addr[1:0] != 2'b00));
      stall   = rst_n & (((state == S_IDLE) & accept) | (state == S_RD) | (state == S_WR));
   end

   // Store lane replication and byte enables; loads never write.
   always_comb begin
      we_n    = '0;
      wdata_n = wdata;
      case (length)
         2'b00: begin
            wdata_n = {4{wdata[7:0]}};
            we_n    = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            wdata_n = {2{wdata[15:0]}};
            we_n    = 4'b0011 << addr[1:0];
         end
         default: begin
            wdata_n = wdata;
            we_n    = 4'b1111;
         end
      endcase
      if (mem_read) we_n = '0;
   end

   // Load lane selection and sign/zero extension; timeout detection.
   always_comb begin
      lane     = dmem.dmem_rdata >> {off_q, 3'b000};
      load_ext = dmem.dmem_rdata;
      case (len_q)
         2'b00:   load_ext = sign_q ? {{24{lane[7]}}, lane[7:0]}   : {24'h0, lane[7:0]};
         2'b01:   load_ext = sign_q ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
         default: load_ext = dmem.dmem_rdata;
      endcase
      // The wait counter would reach TIMEOUT on this edge.
      timeout_hit = (({1'b0, cnt} + 9'd1) == TO_LIMIT);
   end

   // Access FSM with registered memory bus and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cnt             <= '0;
         off_q           <= '0;
         len_q           <= '0;
         sign_q          <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         rdata_out       <= '0;
         dmem.dmem_en    <= 1'b0;
         dmem.dmem_we    <= '0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (accept) begin
                  if (illegal) begin
                     state <= S_RESP;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     off_q           <= addr[1:0];
                     len_q           <= length;
                     sign_q          <= sign;
                     cnt             <= '0;
                     dmem.dmem_en    <= 1'b1;
                     dmem.dmem_we    <= we_n;
                     dmem.dmem_addr  <= {addr[31:2], 2'b00};
                     dmem.dmem_wdata <= wdata_n;
                     state           <= mem_read ? S_RD : S_WR;
                  end
               end
            end
            S_RD, S_WR: begin
               if (dmem.dmem_ready) begin
                  dmem.dmem_en <= 1'b0;
                  done         <= 1'b1;
                  err          <= 1'b0;
                  state        <= S_RESP;
                  if (state == S_RD) rdata_out <= load_ext;
               end else if (timeout_hit) begin
                  dmem.dmem_en <= 1'b0;
                  done         <= 1'b1;
                  err          <= 1'b1;
                  state        <= S_RESP;
                  if (state == S_RD) rdata_out <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               done  <= 1'b0;
               err   <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
